// File: rtl/spi_cmd_engine.sv
// spi_cmd_engine: SD-card SPI command engine. Serialises a 48-bit command frame
//   on MOSI (SPI mode 0), then polls MISO with 0xFF bytes until an R1 response arrives.
// Ports: spi_clk_i/spi_rst_i clock and async active-high reset; spi_data_i command frame;
//   spi_statusreg_i {N[8:6], rsvd, rd, wr, msb_first, ss_high, start}; spi_miso_i card data;
//   spi_sclk_o/spi_mosi_o/spi_ss_o SPI bus; spi_r1_o last R1; spi_flagreg_o {0, OPERT_DONE, WORD_COM};
//   spi_timeout_o sticky no-response flag.
module spi_cmd_engine #(
  parameter int NCR_MAX  = 8,
  parameter int CMD_BITS = 48
) (
  input  logic                spi_clk_i,
  input  logic                spi_rst_i,
  input  logic [CMD_BITS-1:0] spi_data_i,
  input  logic [8:0]          spi_statusreg_i,
  input  logic                spi_miso_i,
  output logic                spi_sclk_o,
  output logic                spi_mosi_o,
  output logic                spi_ss_o,
  output logic [7:0]          spi_r1_o,
  output logic [2:0]          spi_flagreg_o,
  output logic                spi_timeout_o
);

  localparam int              BW          = $clog2(CMD_BITS + 1);
  localparam logic [BW-1:0]   C_CMD_BITS  = BW'(CMD_BITS);
  localparam logic [BW-1:0]   C_BYTE_BITS = BW'(8);
  localparam logic [7:0]      C_NCR_LAST  = 8'(NCR_MAX - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_POLL, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CMD_BITS-1:0] r_shift;
  logic                r_msb;
  logic                r_ssh;
  logic [2:0]          r_n;
  logic [2:0]          r_div;
  logic                r_sclk;
  logic                r_mosi;
  logic [BW-1:0]       r_bits;     // rising edges in current phase (frame or poll byte)
  logic [2:0]          r_rcnt;     // rising edges modulo 8, for WORD_COM
  logic                r_word;
  logic [7:0]          r_rx;
  logic [7:0]          r_pbytes;
  logic [7:0]          r_r1;
  logic                r_timeout;
  logic                w_active;
  logic                w_tick;
  logic                w_rise;
  logic                w_fall;
  logic                w_done;
  logic                w_unused;

  // rd/wr/reserved bits carry intent for other blocks only
  assign w_unused = ^spi_statusreg_i[5:3];

  assign w_active = (r_state == S_SHIFT) || (r_state == S_POLL);
  assign w_tick   = w_active && (r_div == r_n);
  assign w_rise   = w_tick && !r_sclk;
  assign w_fall   = w_tick && r_sclk;

  // State register
  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (spi_statusreg_i[0]) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_fall && (r_bits == C_CMD_BITS)) w_next = r_ssh ? S_DONE : S_POLL;
      // a poll byte is judged on the falling edge after its 8th bit so SCLK ends low
      S_POLL:  if (w_fall && (r_bits == C_BYTE_BITS) && (!r_rx[7] || (r_pbytes == C_NCR_LAST)))
                 w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; ss follows the live input during LOAD so
  // a back-to-back command shows exactly one high cycle (the IDLE cycle)
  always_comb begin
    spi_ss_o = 1'b1;
    w_done   = 1'b0;
    case (r_state)
      S_LOAD:          spi_ss_o = spi_statusreg_i[1];
      S_SHIFT, S_POLL: spi_ss_o = r_ssh;
      S_DONE: begin
        spi_ss_o = r_ssh;
        w_done   = 1'b1;
      end
      default:         spi_ss_o = 1'b1;
    endcase
  end

  // Datapath: divider, shifter, receiver, counters
  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      r_shift   <= '0;
      r_msb     <= 1'b0;
      r_ssh     <= 1'b0;
      r_n       <= 3'd0;
      r_div     <= 3'd0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b1;
      r_bits    <= '0;
      r_rcnt    <= 3'd0;
      r_word    <= 1'b0;
      r_rx      <= 8'hFF;
      r_pbytes  <= 8'd0;
      r_r1      <= 8'hFF;
      r_timeout <= 1'b0;
    end else begin
      r_word <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_shift   <= spi_data_i;
          r_msb     <= spi_statusreg_i[2];
          r_ssh     <= spi_statusreg_i[1];
          r_n       <= spi_statusreg_i[8:6];
          r_timeout <= 1'b0;
          r_div     <= 3'd0;
          r_sclk    <= 1'b0;
          r_mosi    <= spi_statusreg_i[2] ? spi_data_i[CMD_BITS-1] : spi_data_i[0];
          r_bits    <= '0;
          r_rcnt    <= 3'd0;
          r_rx      <= 8'hFF;
          r_pbytes  <= 8'd0;
        end
        S_SHIFT, S_POLL: begin
          if (w_tick) begin
            r_div  <= 3'd0;
            r_sclk <= !r_sclk;
          end else begin
            r_div  <= r_div + 3'd1;
          end
          if (w_rise) begin
            r_bits <= r_bits + 1'b1;
            r_rcnt <= r_rcnt + 3'd1;
            r_word <= (r_rcnt == 3'd7);
            r_rx   <= {r_rx[6:0], spi_miso_i};
          end
          if (w_fall) begin
            if (r_state == S_SHIFT) begin
              if (r_bits == C_CMD_BITS) begin
                r_mosi <= 1'b1;
                r_bits <= '0;
              end else if (r_msb) begin
                r_mosi  <= r_shift[CMD_BITS-2];
                r_shift <= {r_shift[CMD_BITS-2:0], 1'b0};
              end else begin
                r_mosi  <= r_shift[1];
                r_shift <= {1'b0, r_shift[CMD_BITS-1:1]};
              end
            end else if (r_bits == C_BYTE_BITS) begin
              r_bits   <= '0;
              r_pbytes <= r_pbytes + 8'd1;
              if (!r_rx[7]) begin
                r_r1 <= r_rx;
              end else if (r_pbytes == C_NCR_LAST) begin
                r_r1      <= 8'hFF;
                r_timeout <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_sclk_o    = r_sclk;
  assign spi_mosi_o    = r_mosi;
  assign spi_r1_o      = r_r1;
  assign spi_timeout_o = r_timeout;
  assign spi_flagreg_o = {1'b0, w_done, r_word};

endmodule

// File: tb/tb_spi_cmd_engine.sv
// tb_spi_cmd_engine: table-driven bench for spi_cmd_engine with a behavioural SD card
//   on MISO and a scoreboard of expected frames / R1 / timeout popped at each OPERT_DONE.
module tb_spi_cmd_engine;

  logic        clk;
  logic        rst;
  logic [47:0] data;
  logic [8:0]  status;
  logic        miso;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic [7:0]  r1;
  logic [2:0]  flags;
  logic        tmo;

  int n_checks = 0;
  int n_errors = 0;

  spi_cmd_engine #(.NCR_MAX(8), .CMD_BITS(48)) dut (
    .spi_clk_i       (clk),
    .spi_rst_i       (rst),
    .spi_data_i      (data),
    .spi_statusreg_i (status),
    .spi_miso_i      (miso),
    .spi_sclk_o      (sclk),
    .spi_mosi_o      (mosi),
    .spi_ss_o        (ss),
    .spi_r1_o        (r1),
    .spi_flagreg_o   (flags),
    .spi_timeout_o   (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] data;
    logic [8:0]  status;
    int          nff;        // 0xFF bytes the card sends before resp
    logic [7:0]  resp;
    logic [7:0]  exp_r1;
    logic        exp_to;
    int          exp_poll;   // poll bytes clocked
    int          exp_words;  // WORD_COM pulses
    int          exp_period; // spi_clk cycles per SCLK period
  } vec_t;

  typedef struct {
    logic [47:0] seq;        // bit j = j-th bit sent on MOSI
    logic [7:0]  r1;
    logic        to;
  } sb_t;

  vec_t vecs[5];
  sb_t  sb_q[$];

  // results gathered by watch_op
  logic [47:0] cap;
  int          rises;
  int          words;
  int          t0;
  int          t1;
  int          ss_bad;
  int          f2_bad;
  logic        got_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] frame_seq(input logic [47:0] d, input logic msb);
    logic [47:0] s;
    for (int j = 0; j < 48; j++) s[j] = msb ? d[47-j] : d[j];
    return s;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sclk"},  64'(sclk),  64'd0);
    chk({tag, "_mosi"},  64'(mosi),  64'd1);
    chk({tag, "_ss"},    64'(ss),    64'd1);
    chk({tag, "_r1"},    64'(r1),    64'hFF);
    chk({tag, "_flags"}, 64'(flags), 64'd0);
    chk({tag, "_tmo"},   64'(tmo),   64'd0);
  endtask

  // Follow one operation until OPERT_DONE, acting as the card on MISO.
  task automatic watch_op(input string tag, input int nff, input logic [7:0] resp, input logic exp_ss);
    logic       prev;
    logic [7:0] b;
    int         idx;
    rises = 0; words = 0; ss_bad = 0; f2_bad = 0; got_done = 1'b0;
    t0 = 0; t1 = 0; cap = '0; miso = 1'b1; prev = sclk;
    for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
      @(negedge clk);
      if (flags[0]) words++;
      if (flags[2]) f2_bad++;
      if (sclk && !prev) begin
        if (rises < 48) cap[rises] = mosi;
        if (ss !== exp_ss) ss_bad++;
        if (rises == 0) t0 = cyc;
        if (rises == 1) t1 = cyc;
        rises++;
      end
      if (!sclk && prev && rises >= 48) begin
        idx  = rises - 48;
        b    = ((idx / 8) < nff) ? 8'hFF : resp;
        miso = b[7 - (idx % 8)];
      end
      prev = sclk;
      if (flags[1]) got_done = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
  endtask

  task automatic sb_check(input string tag);
    sb_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_frame"}, 64'(cap), 64'(e.seq));
      chk({tag, "_r1"},    64'(r1),  64'(e.r1));
      chk({tag, "_tmo"},   64'(tmo), 64'(e.to));
    end
  endtask

  task automatic post_idle(input string tag);
    int extra;
    extra = 0;
    @(negedge clk);
    chk({tag, "_ss_after_done"}, 64'(ss), 64'd1);
    repeat (4) begin
      @(negedge clk);
      if (flags[1]) extra++;
    end
    chk({tag, "_extra_done"}, 64'(extra), 64'd0);
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    sb_t   e;
    string tag;
    v   = vecs[i];
    tag = $sformatf("v%0d", i);
    e.seq = frame_seq(v.data, v.status[2]);
    e.r1  = v.exp_r1;
    e.to  = v.exp_to;
    sb_q.push_back(e);
    @(negedge clk);
    data = v.data; status = v.status;
    @(negedge clk);                         // LOAD
    status[0] = 1'b0;
    @(negedge clk);                         // first SHIFT cycle: scramble, must be ignored
    data = ~v.data; status = ~v.status; status[0] = 1'b0;
    watch_op(tag, v.nff, v.resp, v.status[1]);
    sb_check(tag);
    chk({tag, "_sclk_edges"}, 64'(rises),   64'(48 + 8 * v.exp_poll));
    chk({tag, "_word_com"},   64'(words),   64'(v.exp_words));
    chk({tag, "_period"},     64'(t1 - t0), 64'(v.exp_period));
    chk({tag, "_ss_level"},   64'(ss_bad),  64'd0);
    chk({tag, "_flag2"},      64'(f2_bad),  64'd0);
    post_idle(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    int  n_done;
    int  n_ss;
    int  hit;
    //           data              status        nff resp   r1     to  poll words period
    vecs[0] = '{48'h400000000095, 9'b101000101, 2, 8'h01, 8'h01, 0, 3,   9,  12};
    vecs[1] = '{48'hFFFFFFFFFFFF, 9'b101000111, 0, 8'hFF, 8'h01, 0, 0,   6,  12};
    vecs[2] = '{48'h123456789ABC, 9'b000000101, 8, 8'hFF, 8'hFF, 1, 8,   14, 2};
    vecs[3] = '{48'h000000000001, 9'b001000001, 0, 8'h00, 8'h00, 0, 1,   7,  4};
    vecs[4] = '{48'h770000000001, 9'b010010101, 1, 8'h05, 8'h05, 0, 2,   8,  6};

    rst = 1'b1; data = '0; status = '0; miso = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("init");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ss", 64'(ss), 64'd1);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset asserted mid-frame with SCLK high
    @(negedge clk);
    data = '0; status = 9'b101000101;
    @(negedge clk);
    status[0] = 1'b0;
    hit = 0; rises = 0;
    for (int cyc = 0; cyc < 2000 && hit == 0; cyc++) begin
      logic p;
      p = sclk;
      @(negedge clk);
      if (sclk && !p) rises++;
      if (rises >= 20 && sclk) hit = 1;
    end
    chk("rst_reached_shift", 64'(hit), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("rst_mid");
    rst = 1'b0;
    n_done = 0; n_ss = 0;
    repeat (20) begin
      @(negedge clk);
      if (flags[1]) n_done++;
      if (ss !== 1'b1) n_ss++;
    end
    chk("rst_no_done", 64'(n_done), 64'd0);
    chk("rst_ss_high", 64'(n_ss),   64'd0);

    // Start held high across DONE: one IDLE cycle, then the next command
    e.seq = frame_seq(48'h400000000095, 1'b1); e.r1 = 8'h00; e.to = 1'b0;
    sb_q.push_back(e);
    sb_q.push_back(e);
    @(negedge clk);
    data = 48'h400000000095; status = 9'b000000101;
    @(negedge clk);                         // LOAD
    watch_op("b2b1", 0, 8'h00, 1'b0);
    sb_check("b2b1");
    @(negedge clk);
    chk("b2b_gap_ss_high", 64'(ss),       64'd1);
    chk("b2b_gap_no_done", 64'(flags[1]), 64'd0);
    @(negedge clk);
    chk("b2b_load_ss_low", 64'(ss),       64'd0);
    watch_op("b2b2", 0, 8'h00, 1'b0);
    status[0] = 1'b0;
    sb_check("b2b2");
    chk("b2b2_word_com", 64'(words), 64'd7);
    post_idle("b2b2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
